// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx
// Brief    : Parallel-in serial-out transmitter. It has a one-word hold buffer,
//            a per-bit valid strobe and optional idle gap between words.
// Revision : 1.0
// ============================================================================
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_piso,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             data_out,
  output logic             valid,
  output logic             word_done,
  output logic             busy
);

  localparam int c_CNT_W = $clog2(WIDTH);
  localparam int c_GAP_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAPW  = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_shift;
  logic [WIDTH-1:0]     r_hold;
  logic                 r_hfull;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_GAP_W-1:0]   r_gcnt;
  logic                 r_ready;
  logic                 r_data_out;
  logic                 r_valid;
  logic                 r_word_done;

  logic                 w_hold_first;
  logic [WIDTH-1:0]     w_hold_rest;
  logic                 w_shift_bit;
  logic [WIDTH-1:0]     w_shift_rest;
  logic                 w_last;
  logic                 w_pre_last;
  logic                 w_gap_last;
  logic                 w_accept;
  logic                 w_consume;
  logic                 w_hfull_nxt;

  assign w_hold_first = (LSB_FIRST != 0) ? r_hold[0] : r_hold[WIDTH-1];
  assign w_hold_rest  = (LSB_FIRST != 0) ? (r_hold >> 1) : (r_hold << 1);
  assign w_shift_bit  = (LSB_FIRST != 0) ? r_shift[0] : r_shift[WIDTH-1];
  assign w_shift_rest = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);

  assign w_last     = (r_cnt == c_CNT_W'(WIDTH - 1));
  assign w_pre_last = (r_cnt == c_CNT_W'(WIDTH - 2));
  assign w_gap_last = (r_gcnt == c_GAP_W'(GAP - 1));

  assign w_accept  = load & r_ready & en_piso;
  // The hold buffer drains into the shifter on exactly these edges.
  assign w_consume = r_hfull & ((r_state == S_IDLE) |
                                ((r_state == S_SHIFT) & w_last & (GAP == 0)) |
                                ((r_state == S_GAPW) & w_gap_last));
  assign w_hfull_nxt = w_accept | (r_hfull & ~w_consume);

  assign ready     = r_ready;
  assign data_out  = r_data_out;
  assign valid     = r_valid;
  assign word_done = r_word_done;
  assign busy      = (r_state != S_IDLE) | r_hfull;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hfull     <= 1'b0;
      r_cnt       <= '0;
      r_gcnt      <= '0;
      r_ready     <= 1'b0;
      r_data_out  <= 1'b0;
      r_valid     <= 1'b0;
      r_word_done <= 1'b0;
    end else if (!en_piso) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hfull     <= 1'b0;
      r_cnt       <= '0;
      r_gcnt      <= '0;
      r_ready     <= 1'b0;
      r_valid     <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold <= data_in;
      end
      r_hfull     <= w_hfull_nxt;
      r_ready     <= ~w_hfull_nxt;
      r_word_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (r_hfull) begin
            r_shift    <= w_hold_rest;
            r_data_out <= w_hold_first;
            r_valid    <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!w_last) begin
            r_shift     <= w_shift_rest;
            r_data_out  <= w_shift_bit;
            r_valid     <= 1'b1;
            r_cnt       <= r_cnt + 1'b1;
            r_word_done <= w_pre_last;
          end else if (GAP == 0 && r_hfull) begin
            r_shift    <= w_hold_rest;
            r_data_out <= w_hold_first;
            r_valid    <= 1'b1;
            r_cnt      <= '0;
          end else if (GAP > 0) begin
            r_valid <= 1'b0;
            r_gcnt  <= '0;
            r_state <= S_GAPW;
          end else begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_GAPW: begin
          r_valid <= 1'b0;
          if (w_gap_last) begin
            if (r_hfull) begin
              r_shift    <= w_hold_rest;
              r_data_out <= w_hold_first;
              r_valid    <= 1'b1;
              r_cnt      <= '0;
              r_state    <= S_SHIFT;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_tx
// Brief    : Self-checking bench for piso_tx. It covers LSB-first, gap and MSB-first instances.
// Revision : 1.0
// ============================================================================
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       en  [3];
  logic       ld  [3];
  logic [7:0] din [3];
  logic       rdy [3];
  logic       dout[3];
  logic       vld [3];
  logic       wd  [3];
  logic       bsy [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(8), .LSB_FIRST(1), .GAP(0)) u_lsb (
    .clk(clk), .rst(rst), .en_piso(en[0]), .data_in(din[0]), .load(ld[0]),
    .ready(rdy[0]), .data_out(dout[0]), .valid(vld[0]), .word_done(wd[0]), .busy(bsy[0]));
  piso_tx #(.WIDTH(8), .LSB_FIRST(1), .GAP(2)) u_gap (
    .clk(clk), .rst(rst), .en_piso(en[1]), .data_in(din[1]), .load(ld[1]),
    .ready(rdy[1]), .data_out(dout[1]), .valid(vld[1]), .word_done(wd[1]), .busy(bsy[1]));
  piso_tx #(.WIDTH(8), .LSB_FIRST(0), .GAP(0)) u_msb (
    .clk(clk), .rst(rst), .en_piso(en[2]), .data_in(din[2]), .load(ld[2]),
    .ready(rdy[2]), .data_out(dout[2]), .valid(vld[2]), .word_done(wd[2]), .busy(bsy[2]));

  // Reference: serial stream is each word's bits in wire order, words concatenated.
  function automatic logic [63:0] model_bits(input logic [31:0] ws, input int n, input bit lsb);
    logic [63:0] s;
    logic [7:0]  w;
    s = '0;
    for (int m = 0; m < n; m++) begin
      w = ws[8*m +: 8];
      for (int k = 0; k < 8; k++) s[8*m+k] = lsb ? w[k] : w[7-k];
    end
    return s;
  endfunction

  function automatic logic [63:0] model_wd(input int n);
    logic [63:0] s;
    s = '0;
    for (int m = 0; m < n; m++) s[8*m+7] = 1'b1;
    return s;
  endfunction

  task automatic send(input int i, input logic [7:0] w);
    int t = 0;
    while (!rdy[i] && t < 100) begin @(negedge clk); t++; end
    checks++;
    if (rdy[i] !== 1'b1) begin
      errors++;
      $display("FAIL send_ready u%0d: ready=%b required 1", i, rdy[i]);
    end
    din[i] = w;
    ld[i]  = 1'b1;
    @(negedge clk);
    ld[i]  = 1'b0;
  endtask

  task automatic collect(input int i, input int nbits, output logic [63:0] bits,
                         output logic [63:0] wdm, output int idles, output int got);
    int t = 0;
    bits = '0; wdm = '0; idles = 0; got = 0;
    while (got < nbits && t < 400) begin
      @(negedge clk); t++;
      if (vld[i]) begin
        bits[got] = dout[i];
        wdm[got]  = wd[i];
        got++;
      end else if (got > 0) begin
        idles++;
      end
    end
  endtask

  task automatic xfer(input int i, input logic [31:0] ws, input int n,
                      output logic [63:0] bits, output logic [63:0] wdm,
                      output int idles, output int got);
    fork
      begin
        for (int k = 0; k < n; k++) send(i, ws[8*k +: 8]);
      end
      collect(i, n*8, bits, wdm, idles, got);
    join
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({vld[i], dout[i], wd[i], bsy[i], rdy[i]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_outputs u%0d: {v,d,wd,busy,rdy}=%b required 00000", i,
                 {vld[i], dout[i], wd[i], bsy[i], rdy[i]});
      end
    end
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_reset u%0d: ready=%b required 1", i, rdy[i]);
      end
    end
  endtask

  task automatic test_single;
    logic [7:0] w = 8'hA5;
    din[0] = w; ld[0] = 1'b1;
    @(negedge clk);
    ld[0] = 1'b0;
    checks++;
    if ({vld[0], bsy[0], rdy[0]} !== 3'b010) begin
      errors++;
      $display("FAIL single_accept: {v,busy,rdy}=%b required 010", {vld[0], bsy[0], rdy[0]});
    end
    @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      checks++;
      if ({vld[0], dout[0], wd[0]} !== {1'b1, w[j], (j == 7)}) begin
        errors++;
        $display("FAIL single_bit%0d: {v,d,wd}=%b required %b", j,
                 {vld[0], dout[0], wd[0]}, {1'b1, w[j], (j == 7)});
      end
      @(negedge clk);
    end
    checks++;
    if ({vld[0], bsy[0]} !== 2'b00) begin
      errors++;
      $display("FAIL single_end: {v,busy}=%b required 00", {vld[0], bsy[0]});
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] bits, wdm;
    int idles, got;
    logic [31:0] ws;
    ws = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'hC3, 8'h3C};
    xfer(0, ws, 4, bits, wdm, idles, got);
    checks++;
    if (got != 32 || bits !== model_bits(ws, 4, 1'b1)) begin
      errors++;
      $display("FAIL b2b_stream: got=%0d bits=%h required 32 bits=%h", got, bits, model_bits(ws, 4, 1'b1));
    end
    checks++;
    if (wdm !== model_wd(4)) begin
      errors++;
      $display("FAIL b2b_word_done: mask=%h required %h", wdm, model_wd(4));
    end
    checks++;
    if (idles != 0) begin
      errors++;
      $display("FAIL b2b_bubbles: idle=%0d required 0", idles);
    end
    @(negedge clk);
    checks++;
    if ({vld[0], bsy[0]} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_end: {v,busy}=%b required 00", {vld[0], bsy[0]});
    end
  endtask

  task automatic test_gap;
    logic [63:0] bits, wdm;
    int idles, got;
    logic [31:0] ws;
    for (int r = 0; r < 2; r++) begin
      int n;
      n  = (r == 0) ? 2 : 3;
      ws = (r == 0) ? 32'h0000_00FF : 32'($urandom);
      xfer(1, ws, n, bits, wdm, idles, got);
      checks++;
      if (got != n*8 || bits !== model_bits(ws, n, 1'b1)) begin
        errors++;
        $display("FAIL gap_stream%0d: got=%0d bits=%h required %0d bits=%h", r, got, bits, n*8,
                 model_bits(ws, n, 1'b1));
      end
      checks++;
      if (idles != 2*(n-1) || wdm !== model_wd(n)) begin
        errors++;
        $display("FAIL gap_idle%0d: idle=%0d wd=%h required idle=%0d wd=%h", r, idles, wdm,
                 2*(n-1), model_wd(n));
      end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_hold_full;
    logic [63:0] bits, wdm;
    int idles, got, extra;
    logic [31:0] ws;
    ws = {16'h0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    fork
      begin
        send(0, ws[7:0]);
        send(0, ws[15:8]);
        checks++;
        if (rdy[0] !== 1'b0) begin
          errors++;
          $display("FAIL hold_full_ready: ready=%b required 0", rdy[0]);
        end
        din[0] = 8'h55; ld[0] = 1'b1;
        @(negedge clk);
        ld[0] = 1'b0;
      end
      collect(0, 16, bits, wdm, idles, got);
    join
    checks++;
    if (got != 16 || bits !== model_bits(ws, 2, 1'b1) || idles != 0) begin
      errors++;
      $display("FAIL hold_full_stream: got=%0d bits=%h idle=%0d required 16 bits=%h idle=0", got, bits,
               idles, model_bits(ws, 2, 1'b1));
    end
    extra = 0;
    repeat (20) begin @(negedge clk); if (vld[0]) extra++; end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL hold_full_dropped: extra valid=%0d required 0", extra);
    end
  endtask

  task automatic test_enable;
    logic [63:0] bits, wdm;
    int idles, got, n, t, live;
    send(0, 8'h0F);
    n = 0; t = 0;
    while (n < 3 && t < 20) begin @(negedge clk); t++; if (vld[0]) n++; end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL enable_prefix: bits=%0d required 3", n);
    end
    en[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({vld[0], wd[0], bsy[0], rdy[0]} !== 4'b0000) begin
      errors++;
      $display("FAIL enable_flush: {v,wd,busy,rdy}=%b required 0000", {vld[0], wd[0], bsy[0], rdy[0]});
    end
    din[0] = 8'hFF; ld[0] = 1'b1;
    live = 0;
    repeat (3) begin @(negedge clk); if (vld[0] || bsy[0]) live++; end
    ld[0] = 1'b0;
    checks++;
    if (live != 0) begin
      errors++;
      $display("FAIL enable_load_ignored: active cycles=%0d required 0", live);
    end
    en[0] = 1'b1;
    @(negedge clk);
    xfer(0, 32'h0000_0081, 1, bits, wdm, idles, got);
    checks++;
    if (got != 8 || bits !== model_bits(32'h81, 1, 1'b1) || wdm !== model_wd(1)) begin
      errors++;
      $display("FAIL enable_resume: got=%0d bits=%h wd=%h required 8 bits=%h wd=%h", got, bits, wdm,
               model_bits(32'h81, 1, 1'b1), model_wd(1));
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_msb;
    logic [63:0] bits, wdm;
    int idles, got;
    logic [31:0] ws;
    ws = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'h80};
    xfer(2, ws, 3, bits, wdm, idles, got);
    checks++;
    if (got != 24 || bits !== model_bits(ws, 3, 1'b0)) begin
      errors++;
      $display("FAIL msb_stream: got=%0d bits=%h required 24 bits=%h", got, bits, model_bits(ws, 3, 1'b0));
    end
    checks++;
    if (wdm !== model_wd(3) || idles != 0) begin
      errors++;
      $display("FAIL msb_framing: wd=%h idle=%0d required wd=%h idle=0", wdm, idles, model_wd(3));
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n, t;
    send(0, 8'($urandom_range(0, 255)) | 8'h02);
    n = 0; t = 0;
    while (n < 2 && t < 20) begin @(negedge clk); t++; if (vld[0]) n++; end
    checks++;
    if ({vld[0], dout[0]} !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_prefix: {v,d}=%b required 11", {vld[0], dout[0]});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({vld[0], dout[0], wd[0], bsy[0], rdy[0]} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_async: {v,d,wd,busy,rdy}=%b required 00000",
               {vld[0], dout[0], wd[0], bsy[0], rdy[0]});
    end
    @(negedge clk);
    checks++;
    if (rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ready_low: ready=%b required 0", rdy[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdy[0], vld[0], bsy[0]} !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid_release: {rdy,v,busy}=%b required 100", {rdy[0], vld[0], bsy[0]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b1; ld[i] = 1'b0; din[i] = '0;
    end
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_gap;
    test_hold_full;
    test_enable;
    test_msb;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
